// File: rtl/pdp8_pkg.sv
// Shared widths and the fetch-state type for the PDP-8 style instruction fetch unit.
// The other fetch-unit files import this package.
package pdp8_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } fetch_state_t;

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter for the fetch unit.
// It resets to START_ADDR. A load takes priority over an increment, and the increment wraps naturally at the address width.
module ifu_pc_reg
    import pdp8_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o0200
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_pc,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [ADDR_WIDTH-1:0] pc_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg <= START_ADDR;
        end else if (load) begin
            pc_reg <= load_pc;
        end else if (inc) begin
            pc_reg <= pc_reg + ADDR_WIDTH'(1);
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller.
// It issues one memory read per instruction, captures the returned word and holds it until the decoder accepts it.
module ifu_fetch_ctrl
    import pdp8_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o0200
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  halt,
    output logic                  ifu_rd_req,
    output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    input  logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_pc,
    output logic                  fetch_busy
);

    fetch_state_t          state_reg, state_next;
    logic                  drop_reg, drop_next;
    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [ADDR_WIDTH-1:0] ipc_reg;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pc_load;
    logic                  pc_inc;
    logic                  capture;
    logic                  release_instr;

    ifu_pc_reg #(
        .START_ADDR(START_ADDR)
    ) u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pc_load),
        .load_pc (branch_pc),
        .inc     (pc_inc),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            drop_reg  <= drop_next;
        end
    end

    // drop_reg marks an in-flight read whose data belongs to a pre-branch PC.
    always_comb begin
        state_next    = state_reg;
        drop_next     = drop_reg;
        pc_load       = 1'b0;
        pc_inc        = 1'b0;
        capture       = 1'b0;
        release_instr = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                pc_load = branch_valid;
                if (start) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                pc_load    = branch_valid;
                drop_next  = branch_valid;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                drop_next = 1'b0;
                if (branch_valid) begin
                    pc_load    = 1'b1;
                    state_next = ST_REQ;
                end else if (drop_reg) begin
                    state_next = ST_REQ;
                end else begin
                    capture    = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (branch_valid || instr_ready) begin
                    pc_load       = branch_valid;
                    pc_inc        = !branch_valid;
                    release_instr = 1'b1;
                    state_next    = halt ? ST_IDLE : ST_REQ;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            ipc_reg   <= '0;
        end else if (capture) begin
            valid_reg <= 1'b1;
            data_reg  <= ifu_rd_data;
            ipc_reg   <= pc;
        end else if (release_instr) begin
            valid_reg <= 1'b0;
        end
    end

    assign ifu_rd_req  = (state_reg == ST_REQ);
    assign ifu_rd_addr = pc;
    assign instr_valid = valid_reg;
    assign instr_data  = data_reg;
    assign instr_pc    = ipc_reg;
    assign fetch_busy  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Scoreboard bench for ifu_fetch_ctrl.
// A behavioural fetch model pushes per-cycle, request and delivery expectations, and a negedge monitor pops and compares them.
module tb_ifu_fetch_ctrl;
    import pdp8_pkg::*;

    localparam logic [11:0] KEY   = 12'o5252;
    localparam logic [11:0] START = 12'o0200;
    localparam int M_IDLE = 0, M_REQ = 1, M_WAIT = 2, M_HOLD = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, halt = 1'b0, instr_ready = 1'b0, branch_valid = 1'b0;
    logic [11:0] branch_pc = '0;
    logic        ifu_rd_req, instr_valid, fetch_busy;
    logic [11:0] ifu_rd_addr, instr_pc, instr_data;
    logic [11:0] rd_data = '0;

    int tests = 0;
    int fails = 0;

    ifu_fetch_ctrl #(.START_ADDR(START)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .halt         (halt),
        .ifu_rd_req   (ifu_rd_req),
        .ifu_rd_addr  (ifu_rd_addr),
        .ifu_rd_data  (rd_data),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .branch_valid (branch_valid),
        .branch_pc    (branch_pc),
        .fetch_busy   (fetch_busy)
    );

    always #5 clk = ~clk;

    // Memory responder: the word is the address XOR KEY, returned one cycle after each request.
    always @(posedge clk) rd_data <= ifu_rd_req ? (ifu_rd_addr ^ KEY) : 12'o0000;

    typedef struct {
        logic        req;
        logic [11:0] addr;
        logic        valid;
        logic        busy;
        logic        dp;
        logic [11:0] data;
        logic [11:0] pc;
    } cyc_t;
    typedef struct {
        logic [11:0] pc;
        logic [11:0] data;
    } ins_t;

    cyc_t        cyc_q[$];
    logic [11:0] req_q[$];
    ins_t        ins_q[$];

    // Reference model of the fetch protocol.
    int          m_stage;
    logic [11:0] m_pc, m_hpc, m_hdata;
    bit          m_drop, m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0o expected %0o at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stage = M_IDLE;
        m_pc    = START;
        m_drop  = 0;
        m_valid = 0;
        m_hpc   = '0;
        m_hdata = '0;
    endtask

    task automatic model_advance(input bit s, input bit h, input bit r, input bit bv, input logic [11:0] bpc);
        ins_t t;
        case (m_stage)
            M_IDLE: begin
                if (bv) m_pc = bpc;
                if (s) m_stage = M_REQ;
            end
            M_REQ: begin
                m_drop = bv;
                if (bv) m_pc = bpc;
                m_stage = M_WAIT;
            end
            M_WAIT: begin
                if (bv || m_drop) begin
                    if (bv) m_pc = bpc;
                    m_stage = M_REQ;
                end else begin
                    m_valid = 1;
                    m_hpc   = m_pc;
                    m_hdata = m_pc ^ KEY;
                    m_stage = M_HOLD;
                end
                m_drop = 0;
            end
            default: begin
                if (bv) begin
                    m_pc    = bpc;
                    m_valid = 0;
                    m_stage = h ? M_IDLE : M_REQ;
                end else if (r) begin
                    t.pc    = m_hpc;
                    t.data  = m_hdata;
                    ins_q.push_back(t);
                    m_pc    = 12'((int'(m_pc) + 1) % 4096);
                    m_valid = 0;
                    m_stage = h ? M_IDLE : M_REQ;
                end
            end
        endcase
    endtask

    task automatic step(input bit s, input bit h, input bit r, input bit bv, input logic [11:0] bpc, input bit rst);
        cyc_t c;
        @(posedge clk);
        #1;
        reset_n      = !rst;
        start        = s;
        halt         = h;
        instr_ready  = r;
        branch_valid = bv;
        branch_pc    = bpc;
        if (rst) model_reset();
        c.req   = (m_stage == M_REQ);
        c.addr  = m_pc;
        c.valid = m_valid;
        c.busy  = (m_stage != M_IDLE);
        c.dp    = m_valid || rst;
        c.data  = m_hdata;
        c.pc    = m_hpc;
        cyc_q.push_back(c);
        if (m_stage == M_REQ) req_q.push_back(m_pc);
        if (!rst) model_advance(s, h, r, bv, bpc);
    endtask

    task automatic run_to(input int target, input bit r, input bit h);
        for (int i = 0; i < 20 && m_stage != target; i++) step(0, h, r, 0, '0, 0);
        chk("run_to_stage", m_stage, target);
    endtask

    // Monitor: pops expectations as the DUT presents cycles, requests and accepted instructions.
    always @(negedge clk) begin
        cyc_t        c;
        ins_t        t;
        logic [11:0] a;
        if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            chk("rd_req", ifu_rd_req, c.req);
            chk("rd_addr", ifu_rd_addr, c.addr);
            chk("instr_valid", instr_valid, c.valid);
            chk("fetch_busy", fetch_busy, c.busy);
            if (c.dp) begin
                chk("instr_data", instr_data, c.data);
                chk("instr_pc", instr_pc, c.pc);
            end
        end
        if (ifu_rd_req) begin
            if (req_q.size() == 0) begin
                chk("unexpected_req", 1, 0);
            end else begin
                a = req_q.pop_front();
                $display("[TB] request addr=%04o expect=%04o", ifu_rd_addr, a);
                chk("req_addr", ifu_rd_addr, a);
            end
        end
        if (instr_valid && instr_ready && !branch_valid && reset_n) begin
            if (ins_q.size() == 0) begin
                chk("unexpected_accept", 1, 0);
            end else begin
                t = ins_q.pop_front();
                $display("[TB] accept pc=%04o data=%04o expect pc=%04o data=%04o", instr_pc, instr_data, t.pc, t.data);
                chk("accept_pc", instr_pc, t.pc);
                chk("accept_data", instr_data, t.data);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) step(0, 0, 0, 0, '0, 1);

        // Back-to-back fetches with the decoder always ready.
        step(1, 0, 1, 0, '0, 0);
        repeat (10) step(0, 0, 1, 0, '0, 0);
        run_to(M_HOLD, 0, 0);
        step(0, 1, 1, 0, '0, 0);

        // Decoder stalls in HOLD.
        step(1, 0, 0, 0, '0, 0);
        run_to(M_HOLD, 0, 0);
        repeat (5) step(0, 0, 0, 0, '0, 0);
        step(0, 1, 1, 0, '0, 0);
        step(0, 0, 0, 0, '0, 0);

        // Wrap from 7777 to 0000.
        step(0, 0, 0, 1, 12'o7777, 0);
        step(1, 0, 0, 0, '0, 0);
        run_to(M_HOLD, 0, 0);
        step(0, 0, 1, 0, '0, 0);
        run_to(M_HOLD, 0, 0);
        step(0, 1, 1, 0, '0, 0);

        // Branches in REQ, WAIT and HOLD.
        step(1, 0, 0, 0, '0, 0);
        step(0, 0, 0, 1, 12'o1234, 0);
        run_to(M_WAIT, 0, 0);
        step(0, 0, 0, 1, 12'o0400, 0);
        run_to(M_HOLD, 0, 0);
        step(0, 0, 1, 1, 12'o0400, 0);
        run_to(M_HOLD, 0, 0);
        step(0, 1, 1, 1, 12'o0500, 0);
        step(0, 0, 0, 0, '0, 0);

        // Halt asserted while the request is issued.
        step(1, 0, 0, 0, '0, 0);
        run_to(M_REQ, 0, 0);
        run_to(M_HOLD, 0, 1);
        step(0, 1, 1, 0, '0, 0);
        repeat (2) step(0, 0, 0, 0, '0, 0);

        // Reset in the middle of a fetch.
        step(1, 0, 0, 0, '0, 0);
        run_to(M_WAIT, 0, 0);
        step(0, 0, 0, 0, '0, 1);
        repeat (3) step(0, 0, 1, 0, '0, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom % 5 == 0, $urandom % 4 == 0, $urandom % 3 != 0,
                 $urandom % 9 == 0, 12'($urandom), $urandom % 150 == 0);
        end

        step(0, 1, 0, 0, '0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("req_queue_drained", req_q.size(), 0);
        chk("ins_queue_drained", ins_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
